// File: rtl/teclado_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM encoding, idle column
// and the keypad legend table used when TECLADO_MAPA_HEX_EN is defined.
package teclado_pkg;

    typedef enum logic [1:0] {
        ESCANEO    = 2'd0,
        REBOTE     = 2'd1,
        PRESIONADA = 2'd2,
        LIBERACION = 2'd3
    } estado_t;

    localparam logic [3:0] COL_INICIAL  = 4'b1110;
    localparam logic [3:0] FILAS_LIBRES = 4'hF;

    // Legend indexed by raw code fila*4+col; entry 15 is leftmost.
    localparam logic [15:0][3:0] MAPA_HEX = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    // Lowest low row wins; result is {fila, col} which equals fila*4+col.
    function automatic logic [3:0] codigo_crudo(input logic [3:0] filas,
                                                input logic [3:0] columnas);
        logic [1:0] fila;
        logic [1:0] col;
        if (!filas[0])      fila = 2'd0;
        else if (!filas[1]) fila = 2'd1;
        else if (!filas[2]) fila = 2'd2;
        else                fila = 2'd3;
        case (columnas)
            4'b1110: col = 2'd0;
            4'b1101: col = 2'd1;
            4'b1011: col = 2'd2;
            4'b0111: col = 2'd3;
            default: col = 2'd0;
        endcase
        return {fila, col};
    endfunction

endpackage

// File: rtl/preescalador.sv
// Scan prescaler: counts 0..LIM and raises o_Tick for the single clock where the count equals LIM.
module preescalador #(
    parameter int N   = 17,
    parameter int LIM = 99999
) (
    input  logic i_Clk,
    input  logic i_Rst,
    output logic o_Tick
);

    localparam logic [N-1:0] TERMINAL = N'(LIM);

    logic [N-1:0] r_cont;

    // Free-running counter that wraps to zero after the terminal count.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_cont <= '0;
        end else if (r_cont == TERMINAL) begin
            r_cont <= '0;
        end else begin
            r_cont <= r_cont + N'(1);
        end
    end

    assign o_Tick = (r_cont == TERMINAL);

endmodule

// File: rtl/escaner_teclado_4x4.sv
// 4x4 keypad scanner with debounce; define TECLADO_MAPA_HEX_EN to output the keypad
// legend instead of the raw code fila*4+col.
module escaner_teclado_4x4
    import teclado_pkg::*;
#(
    parameter int N   = 17,
    parameter int LIM = 99999,
    parameter int DEB = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [3:0] i_Filas,
    output logic [3:0] o_Columnas,
    output logic [3:0] o_Tecla,
    output logic       o_Valida,
    output logic       o_Presionada
);

    localparam logic [3:0] DEB_C = 4'(DEB);

    logic       w_tick;
    logic [3:0] w_codigo;
    logic [3:0] w_cnt_sig;
    logic [3:0] r_filas_m;
    logic [3:0] r_filas_s;
    logic [3:0] r_cand;
    logic [3:0] r_cnt;
    logic [3:0] r_columnas;
    logic [3:0] r_tecla;
    logic       r_valida;
    logic       r_presionada;
    estado_t    r_estado;

    preescalador #(.N(N), .LIM(LIM)) u_preescalador (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .o_Tick (w_tick)
    );

    assign w_cnt_sig = r_cnt + 4'd1;

`ifdef TECLADO_MAPA_HEX_EN
    assign w_codigo = MAPA_HEX[codigo_crudo(r_cand, r_columnas)];
`else
    assign w_codigo = codigo_crudo(r_cand, r_columnas);
`endif

    // Two-flop synchronizer for the asynchronous row inputs; idles released.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_filas_m <= FILAS_LIBRES;
            r_filas_s <= FILAS_LIBRES;
        end else begin
            r_filas_m <= i_Filas;
            r_filas_s <= r_filas_m;
        end
    end

    // Scan/debounce FSM; all decisions are taken only on scan ticks.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_estado     <= ESCANEO;
            r_cnt        <= 4'd0;
            r_cand       <= FILAS_LIBRES;
            r_columnas   <= COL_INICIAL;
            r_tecla      <= 4'd0;
            r_valida     <= 1'b0;
            r_presionada <= 1'b0;
        end else begin
            r_valida <= 1'b0;
            if (w_tick) begin
                case (r_estado)
                    ESCANEO: begin
                        if (r_filas_s == FILAS_LIBRES) begin
                            r_columnas <= {r_columnas[2:0], r_columnas[3]};
                        end else begin
                            r_cand   <= r_filas_s;
                            r_cnt    <= 4'd1;
                            r_estado <= REBOTE;
                        end
                    end
                    REBOTE: begin
                        if (r_filas_s != r_cand) begin
                            r_cnt    <= 4'd0;
                            r_estado <= ESCANEO;
                        end else if (w_cnt_sig == DEB_C) begin
                            r_valida     <= 1'b1;
                            r_tecla      <= w_codigo;
                            r_presionada <= 1'b1;
                            r_cnt        <= 4'd0;
                            r_estado     <= PRESIONADA;
                        end else begin
                            r_cnt <= w_cnt_sig;
                        end
                    end
                    PRESIONADA: begin
                        if (r_filas_s == FILAS_LIBRES) begin
                            r_cnt    <= 4'd1;
                            r_estado <= LIBERACION;
                        end else begin
                            r_cnt <= 4'd0;
                        end
                    end
                    LIBERACION: begin
                        if (r_filas_s != FILAS_LIBRES) begin
                            r_cnt    <= 4'd0;
                            r_estado <= PRESIONADA;
                        end else if (w_cnt_sig == DEB_C) begin
                            r_presionada <= 1'b0;
                            r_cnt        <= 4'd0;
                            r_columnas   <= {r_columnas[2:0], r_columnas[3]};
                            r_estado     <= ESCANEO;
                        end else begin
                            r_cnt <= w_cnt_sig;
                        end
                    end
                    default: begin
                        r_cnt    <= 4'd0;
                        r_estado <= ESCANEO;
                    end
                endcase
            end
        end
    end

    assign o_Columnas   = r_columnas;
    assign o_Tecla      = r_tecla;
    assign o_Valida     = r_valida;
    assign o_Presionada = r_presionada;

endmodule
